// File: rtl/fg_pkg.sv
// Function generator shared definitions:
// config layout, pin indices, sine table, saturation.
package fg_pkg;

   localparam int CFG_W     = 56;
   localparam int B_CONST   = 55;
   localparam int B_SINE    = 54;
   localparam int PRE_LSB   = 48;
   localparam int CNT_LSB   = 40;
   localparam int PH_LSB    = 32;
   localparam int RISE_LSB  = 24;
   localparam int FALL_LSB  = 16;
   localparam int AMP_LSB   = 8;
   localparam int OFF_LSB   = 0;

   localparam int UIO_CFG_EN   = 7;
   localparam int UIO_WR_N     = 6;
   localparam int UIO_ADDR_LSB = 3;

   typedef struct packed {
      logic       cnst;
      logic       sine;
      logic [5:0] pre;
      logic [7:0] cnt;
      logic [7:0] phase;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] amp;
      logic [7:0] off;
   } cfg_t;

   typedef enum logic [1:0] {
      MODE_WAVE,
      MODE_SINE,
      MODE_CONST
   } mode_e;

   // round(127*sin(2*pi*i/256)), i = 0..63
   localparam logic [6:0] SINE_Q [64] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
   };

   function automatic logic [7:0] sat8(input logic signed [9:0] v);
      if (v > 10'sd127)
         return 8'h7f;
      if (v < -10'sd128)
         return 8'h80;
      return v[7:0];
   endfunction

   // Full-wave sine from the quarter table; entry 64 is the peak.
   function automatic logic [7:0] sine8(input logic [7:0] p);
      logic [6:0] idx;
      logic [6:0] mag;
      idx = p[6] ? 7'd64 - {1'b0, p[5:0]} : {1'b0, p[5:0]};
      mag = idx[6] ? 7'd127 : SINE_Q[idx[5:0]];
      return p[7] ? 8'd0 - {1'b0, mag} : {1'b0, mag};
   endfunction

endpackage

// File: rtl/fg_if.sv
// Config/sample link between the top and the generator core,
// plus a pin bundle for the chip-level pads.
interface fg_if;
   import fg_pkg::*;

   cfg_t       cfg;
   logic       load;
   logic [7:0] phase;
   logic [7:0] sample;

   modport master (
      output cfg, load, phase,
      input  sample
   );

   modport slave (
      input  cfg, load, phase,
      output sample
   );
endinterface

interface fg_pin_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/fg_core.sv
// Generator datapath: prescaler, tick counter,
// level ramp, phase accumulator and output arithmetic.
module fg_core
   import fg_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   fg_if.slave  bus
);

   cfg_t              cfg;
   logic [5:0]        pre_cnt;
   logic [5:0]        pre_top;
   logic [7:0]        c;
   logic [7:0]        lvl;
   logic [7:0]        ph;
   logic [7:0]        sample;
   logic              tick;
   logic              on;
   logic [8:0]        up;
   logic [7:0]        lvl_up;
   logic [7:0]        lvl_dn;
   logic signed [7:0] s;
   logic signed [15:0] prod;
   logic signed [15:0] scaled;
   logic signed [9:0] off10;
   logic signed [9:0] sum;
   mode_e             mode;

   assign cfg = bus.cfg;

   // Tick detection and clamped level steps (9-bit, no wrap).
   always_comb begin
      pre_top = (cfg.pre == 6'd0) ? 6'd0 : cfg.pre - 6'd1;
      tick    = (pre_cnt == pre_top);
      on      = (c < cfg.phase);
      up      = {1'b0, lvl} + {1'b0, cfg.rise};
      lvl_up  = (up > {1'b0, cfg.amp}) ? cfg.amp : up[7:0];
      lvl_dn  = (lvl > cfg.fall) ? lvl - cfg.fall : 8'd0;
   end

   // Counters, level and phase; a config load restarts everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         c       <= '0;
         lvl     <= '0;
         ph      <= '0;
      end else if (bus.load) begin
         pre_cnt <= '0;
         c       <= '0;
         lvl     <= '0;
         ph      <= bus.phase;
      end else if (tick) begin
         pre_cnt <= '0;
         c       <= (c == cfg.cnt) ? 8'd0 : c + 8'd1;
         lvl     <= on ? lvl_up : lvl_dn;
         ph      <= ph + cfg.cnt;
      end else begin
         pre_cnt <= pre_cnt + 6'd1;
      end
   end

   // Mode select and 10-bit signed output sum.
   always_comb begin
      mode   = cfg.cnst ? MODE_CONST
             : (cfg.sine ? MODE_SINE : MODE_WAVE);
      s      = sine8(ph);
      prod   = $signed({{8{s[7]}}, s})
             * $signed({8'h00, cfg.amp});
      scaled = prod >>> 7;
      off10  = {{2{cfg.off[7]}}, cfg.off};
      sum    = off10;
      unique case (mode)
         MODE_CONST: sum = off10 + $signed({2'b00, cfg.amp});
         MODE_SINE:  sum = off10 + $signed(scaled[9:0]);
         default:    sum = off10 + $signed({2'b00, lvl});
      endcase
   end

   // Registered, saturated sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sample <= '0;
      else
         sample <= sat8(sum);
   end

   assign bus.sample = sample;

endmodule

// File: rtl/tt_um_fg_top_dominik_brandstetter.sv
// Tiny Tapeout function generator top: pin sync,
// byte-wise shadow config and active config.
module tt_um_fg_top_dominik_brandstetter
   import fg_pkg::*;
(
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   logic [1:0]       en_sync;
   logic [1:0]       wr_sync;
   logic             en_q;
   logic             wr_q;
   logic             en_s;
   logic             wr_s;
   logic             wr_evt;
   logic             load;
   logic [2:0]       addr;
   logic [CFG_W-1:0] shadow;
   cfg_t             active;
   logic             unused_ok;

   fg_if link ();

   // Two-flop sync of CFG_EN / WR_N plus edge history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_sync <= 2'b00;
         wr_sync <= 2'b11;
         en_q    <= 1'b0;
         wr_q    <= 1'b1;
      end else begin
         en_sync <= {en_sync[0], uio_in[UIO_CFG_EN]};
         wr_sync <= {wr_sync[0], uio_in[UIO_WR_N]};
         en_q    <= en_sync[1];
         wr_q    <= wr_sync[1];
      end
   end

   assign en_s   = en_sync[1];
   assign wr_s   = wr_sync[1];
   assign wr_evt = en_s & wr_s & ~wr_q;
   assign load   = en_q & ~en_s;
   assign addr   = uio_in[UIO_ADDR_LSB +: 3];

   // Shadow bytes fill during a session; activated when it ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         active <= '0;
      end else begin
         if (wr_evt && addr != 3'd7)
            shadow[{3'd6 - addr, 3'b000} +: 8] <= ui_in;
         if (load)
            active <= cfg_t'(shadow);
      end
   end

   assign link.cfg   = active;
   assign link.load  = load;
   assign link.phase = shadow[PH_LSB +: 8];

   fg_core u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (link.slave)
   );

   assign uo_out    = link.sample;
   assign uio_out   = 8'h00;
   assign uio_oe    = 8'h00;
   assign unused_ok = &{1'b0, ena, uio_in[2:0]};

endmodule

// File: tb/tb_tt_um_fg_top_dominik_brandstetter.sv
// Scoreboard bench for the function generator top:
// pin-level config sessions against a behavioural model.
module tb_tt_um_fg_top_dominik_brandstetter;

   localparam real PI = 3.14159265358979;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ena   = 1'b1;

   fg_pin_if pins ();

   tt_um_fg_top_dominik_brandstetter dut (
      .ui_in   (pins.ui_in),
      .uo_out  (pins.uo_out),
      .uio_in  (pins.uio_in),
      .uio_out (pins.uio_out),
      .uio_oe  (pins.uio_oe),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   always #25 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int sb[$];

   logic [55:0] m_shadow;
   logic [55:0] m_act;
   int m_k, m_c, m_l, m_p;
   int h1, h2, h3;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic int sat(int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic int f_amp(logic [55:0] k); return int'(k[15:8]); endfunction
   function automatic int f_off(logic [55:0] k); return int'($signed(k[7:0])); endfunction

   function automatic int model_out();
      int  amp, off, s;
      real x;
      amp = f_amp(m_act);
      off = f_off(m_act);
      if (m_act[55])
         return sat(off + amp);
      if (m_act[54]) begin
         x = 127.0 * $sin(2.0 * PI * real'(m_p) / 256.0);
         s = $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
         return sat(off + ((s * amp) >>> 7));
      end
      return sat(off + m_l);
   endfunction

   function automatic logic [55:0] mk(
      bit cst, bit sn, int pre, int cnt, int on,
      int rise, int fall, int amp, int off);
      logic [5:0] p6;
      logic [7:0] b [6];
      p6   = 6'(pre);
      b[0] = 8'(cnt);  b[1] = 8'(on);
      b[2] = 8'(rise); b[3] = 8'(fall);
      b[4] = 8'(amp);  b[5] = 8'(off);
      return {cst, sn, p6, b[0], b[1], b[2], b[3], b[4], b[5]};
   endfunction

   // Reference model: one step per clock edge.
   initial begin
      int pmax, rise, fall, amp, cnt, on;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_shadow = '0; m_act = '0;
            m_k = 0; m_c = 0; m_l = 0; m_p = 0;
            h1 = 0; h2 = 0; h3 = 0;
            sb.push_back(0);
         end else begin
            sb.push_back(model_out());
            if (h2 == 0 && h3 == 1) begin
               m_act = m_shadow;
               m_k = 0; m_c = 0; m_l = 0;
               m_p = int'(m_shadow[39:32]);
            end else begin
               pmax = (m_act[53:48] == 0) ? 1 : int'(m_act[53:48]);
               if (m_k == pmax - 1) begin
                  cnt  = int'(m_act[47:40]);
                  on   = int'(m_act[39:32]);
                  rise = int'(m_act[31:24]);
                  fall = int'(m_act[23:16]);
                  amp  = f_amp(m_act);
                  m_k  = 0;
                  if (m_c < on)
                     m_l = (m_l + rise > amp) ? amp : m_l + rise;
                  else
                     m_l = (m_l - fall < 0) ? 0 : m_l - fall;
                  m_c = (m_c == cnt) ? 0 : m_c + 1;
                  m_p = (m_p + cnt) % 256;
               end else begin
                  m_k++;
               end
            end
            h3 = h2; h2 = h1; h1 = int'(pins.uio_in[7]);
         end
      end
   end

   // Monitor: compare each presented sample with the scoreboard.
   initial begin
      int exp;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk("sample", int'($signed(pins.uo_out)), exp);
         end
      end
   end

   task automatic write_byte(int a, logic [7:0] d);
      pins.ui_in = d;
      pins.uio_in[5:3] = 3'(a);
      pins.uio_in[6] = 1'b0;
      repeat (5) @(negedge clk);
      pins.uio_in[6] = 1'b1;
      if (a < 7)
         m_shadow[8*(6-a) +: 8] = d;
      repeat (5) @(negedge clk);
   endtask

   task automatic load_cfg(logic [55:0] k);
      @(negedge clk);
      pins.uio_in[7] = 1'b1;
      repeat (4) @(negedge clk);
      for (int a = 0; a < 7; a++)
         write_byte(a, k[8*(6-a) +: 8]);
      write_byte(7, 8'hA5);
      pins.uio_in[7] = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic run_range(string nm, int n, int mx, int mn);
      int hi, lo, v;
      hi = -1000; lo = 1000;
      repeat (n) begin
         @(negedge clk);
         v = int'($signed(pins.uo_out));
         if (v > hi) hi = v;
         if (v < lo) lo = v;
      end
      chk({nm, "_max"}, hi, mx);
      chk({nm, "_min"}, lo, mn);
   endtask

   initial begin
      pins.ui_in  = 8'h00;
      pins.uio_in = 8'b0100_0000;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_uo", int'(pins.uo_out), 0);
      chk("rst_uio_out", int'(pins.uio_out), 0);
      chk("rst_uio_oe", int'(pins.uio_oe), 0);
      #1 rst_n = 1'b1;
      run_range("idle", 50, 0, 0);

      load_cfg(mk(1, 0, 20, 0, 0, 0, 0, 100, -10));
      chk("const", int'($signed(pins.uo_out)), 90);
      run_range("const_hold", 200, 90, 90);

      load_cfg(mk(0, 0, 20, 99, 50, 254, 254, 100, 10));
      run_range("rect", 4000, 110, 10);

      load_cfg(mk(0, 0, 20, 99, 50, 5, 10, 100, 10));
      run_range("trap", 2500, 110, 10);

      load_cfg(mk(0, 0, 20, 99, 99, 1, 254, 100, 10));
      run_range("saw", 2500, 109, 10);

      load_cfg(mk(0, 1, 40, 6, 64, 0, 0, 50, 0));
      chk("sine_first", int'($signed(pins.uo_out)), 49);
      run_range("sine", 3500, 49, -50);

      load_cfg(mk(1, 0, 0, 0, 0, 0, 0, 100, 100));
      chk("sat_hi", int'($signed(pins.uo_out)), 127);

      load_cfg(mk(0, 1, 1, 64, 192, 0, 0, 255, -128));
      chk("sat_lo", int'($signed(pins.uo_out)), -128);

      for (int i = 0; i < 8; i++) begin
         load_cfg(mk($urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255)));
         repeat (600) @(negedge clk);
      end

      @(negedge clk);
      pins.uio_in[7] = 1'b1;
      repeat (4) @(negedge clk);
      write_byte(0, 8'h80);
      write_byte(5, 8'd77);
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      pins.uio_in[7] = 1'b0;
      repeat (6) @(negedge clk);
      run_range("rst_mid", 100, 0, 0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
